// File: rtl/l0_dmem_responder.sv
// ---------------------------------------------------------------------------
// l0_dmem_responder
//   Backing data memory behind an L0 data cache. Serves line reads (cache
//   misses) with a fixed latency and absorbs line write-backs into a small
//   in-order write buffer that retires into the line array in the background.
//   A read first drains every write accepted before it, so the returned line
//   always reflects all earlier write-backs.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   rd_req_i         line read request
//   rd_addr_i        read byte address
//   rd_busy_o        high while a read is in flight (request not accepted)
//   rvalid_o         one-cycle pulse, rdata_o carries the requested line
//   rdata_o          returned line, held until the next rvalid_o
//   we_i             line write request
//   be_i             per-byte write enables
//   waddr_i          write byte address
//   wdata_i          write line data
//   write_ready_o    high when a write presented this cycle is accepted
// ---------------------------------------------------------------------------
module l0_dmem_responder #(
  parameter int DATA_RAM_WIDTH = 128,
  parameter int LOG2_NUM_LINES = 6,
  parameter int READ_LATENCY   = 2,
  parameter int WBUF_DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rd_req_i,
  input  logic [31:0]                 rd_addr_i,
  output logic                        rd_busy_o,
  output logic                        rvalid_o,
  output logic [DATA_RAM_WIDTH-1:0]   rdata_o,
  input  logic                        we_i,
  input  logic [DATA_RAM_WIDTH/8-1:0] be_i,
  input  logic [31:0]                 waddr_i,
  input  logic [DATA_RAM_WIDTH-1:0]   wdata_i,
  output logic                        write_ready_o
);

  localparam int BE_W      = DATA_RAM_WIDTH / 8;
  localparam int OFF       = $clog2(BE_W);
  localparam int NUM_LINES = 1 << LOG2_NUM_LINES;
  localparam int PTR_W     = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int SLOTS     = 1 << PTR_W;
  localparam int CNT_W     = $clog2(WBUF_DEPTH + 1);

  localparam logic [2:0]       LAT_M1   = 3'(READ_LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WBUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WBUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    READ
  } state_t;

  state_t                     state;
  logic [2:0]                 rd_cnt;
  logic [CNT_W-1:0]           drain_left;
  logic [LOG2_NUM_LINES-1:0]  rd_idx_q;

  logic [DATA_RAM_WIDTH-1:0]  mem [NUM_LINES];

  logic [LOG2_NUM_LINES-1:0]  wb_idx  [SLOTS];
  logic [BE_W-1:0]            wb_be   [SLOTS];
  logic [DATA_RAM_WIDTH-1:0]  wb_data [SLOTS];
  logic [PTR_W-1:0]           head;
  logic [PTR_W-1:0]           tail;
  logic [CNT_W-1:0]           count;

  logic [LOG2_NUM_LINES-1:0]  rd_line_idx;
  logic [LOG2_NUM_LINES-1:0]  wr_line_idx;
  logic                       enq;
  logic                       retire;

  // Only the line-index field of each address is meaningful.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr_i, waddr_i};

  assign rd_line_idx = rd_addr_i[OFF +: LOG2_NUM_LINES];
  assign wr_line_idx = waddr_i[OFF +: LOG2_NUM_LINES];

  assign rd_busy_o     = (state != IDLE);
  assign write_ready_o = (count < CNT_FULL) && (state != DRAIN);
  assign enq           = we_i && write_ready_o;

  // drain_left counts only the entries that were queued before the read was
  // accepted (minus the one retired on the accept edge). Writes enqueued on
  // the accept edge stay buffered so the read returns pre-write data. The
  // final DRAIN cycle with drain_left == 0 retires nothing; that keeps the
  // read latency at N + READ_LATENCY and guarantees no retire coincides with
  // READ entry.
  always_comb begin
    retire = 1'b0;
    if (state == IDLE && count != '0)
      retire = 1'b1;
    else if (state == DRAIN && drain_left != '0)
      retire = 1'b1;
  end

  // Write buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        wb_idx[i]  <= '0;
        wb_be[i]   <= '0;
        wb_data[i] <= '0;
      end
    end else begin
      if (enq) begin
        wb_idx[tail]  <= wr_line_idx;
        wb_be[tail]   <= be_i;
        wb_data[tail] <= wdata_i;
        tail          <= (tail == PTR_LAST) ? '0 : tail + PTR_W'(1);
      end
      if (retire)
        head <= (head == PTR_LAST) ? '0 : head + PTR_W'(1);
      case ({enq, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Line array: byte-masked retire of the buffer head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LINES; i++)
        mem[i] <= '0;
    end else if (retire) begin
      for (int unsigned b = 0; b < BE_W; b++)
        if (wb_be[head][b])
          mem[wb_idx[head]][8*b +: 8] <= wb_data[head][8*b +: 8];
    end
  end

  // Read sequencing. The array cannot change while in READ (no retires), so
  // fetching the line on the rvalid-setting edge equals sampling it on READ
  // entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_cnt     <= '0;
      drain_left <= '0;
      rd_idx_q   <= '0;
      rvalid_o   <= 1'b0;
      rdata_o    <= '0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req_i) begin
            rd_idx_q <= rd_line_idx;
            if (count == '0) begin
              state  <= READ;
              rd_cnt <= LAT_M1;
              if (READ_LATENCY == 1) begin
                rvalid_o <= 1'b1;
                rdata_o  <= mem[rd_line_idx];
              end
            end else begin
              state      <= DRAIN;
              drain_left <= count - CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_left == '0) begin
            state  <= READ;
            rd_cnt <= LAT_M1;
            if (READ_LATENCY == 1) begin
              rvalid_o <= 1'b1;
              rdata_o  <= mem[rd_idx_q];
            end
          end else begin
            drain_left <= drain_left - CNT_W'(1);
          end
        end
        READ: begin
          if (rd_cnt == '0) begin
            state <= IDLE;
          end else begin
            rd_cnt <= rd_cnt - 3'd1;
            if (rd_cnt == 3'd1) begin
              rvalid_o <= 1'b1;
              rdata_o  <= mem[rd_idx_q];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/l0_dmem_responder.md
L0_DMEM_RESPONDER -- requirements
Module: l0_dmem_responder

Interface
REQ-001 Parameter DATA_RAM_WIDTH, default 128, line width in bits; byte-enable width is DATA_RAM_WIDTH/8.
REQ-002 Parameter LOG2_NUM_LINES, default 6, log2 of line count in the backing array.
REQ-003 Parameter READ_LATENCY, default 2, cycles from read start to rvalid_o (legal 1..7).
REQ-004 Parameter WBUF_DEPTH, default 2, write-buffer entries (legal 1..4).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 rd_req_i  in  1  line read request (cache miss).
REQ-008 rd_addr_i  in  32  read byte address.
REQ-009 rd_busy_o  out  1  high: read request not accepted this cycle.
REQ-010 rvalid_o  out  1  one-cycle pulse, rdata_o valid.
REQ-011 rdata_o  out  DATA_RAM_WIDTH  returned line.
REQ-012 we_i  in  1  line write request (dirty write-back).
REQ-013 be_i  in  DATA_RAM_WIDTH/8  per-byte write enables.
REQ-014 waddr_i  in  32  write byte address.
REQ-015 wdata_i  in  DATA_RAM_WIDTH  write line data.
REQ-016 write_ready_o  out  1  high: write accepted this cycle if we_i.

Function
REQ-017 Line index SHALL be addr[log2(DATA_RAM_WIDTH/8) +: LOG2_NUM_LINES]; higher and lower bits ignored.
REQ-018 FSM states SHALL be IDLE, DRAIN, READ.
REQ-019 Read accepted when rd_req_i=1 and rd_busy_o=0; rd_addr_i latched on that edge.
REQ-020 rd_busy_o SHALL be 0 in IDLE, 1 in DRAIN and READ.
REQ-021 IDLE: on accept, next state READ if buffer count (before this cycle's enqueue/dequeue) is 0, else DRAIN.
REQ-022 DRAIN: one buffer entry retired per cycle; when count reaches 0, next state READ.
REQ-023 READ: counter loads READ_LATENCY-1 on entry, decrements per cycle; rdata_o = array line sampled on READ entry; rvalid_o=1 when counter=0, then IDLE.
REQ-024 Latency: accept at cycle T with N buffered writes -> rvalid_o at T+N+READ_LATENCY exactly.
REQ-025 rdata_o SHALL hold last returned line until next rvalid_o.
REQ-026 Write buffer: FIFO, in-order; write_ready_o = (count < WBUF_DEPTH) and state != DRAIN.
REQ-027 Write accepted when we_i=1 and write_ready_o=1; waddr_i, be_i, wdata_i enqueued.
REQ-028 Retire: in IDLE and DRAIN, head entry written to array, only bytes with be=1 modified.
REQ-029 No retire in READ; writes still accepted in READ until full.
REQ-030 Same-cycle enqueue and retire: count unchanged; full buffer with retire still reports write_ready_o=0 that cycle.
REQ-031 Ordering: read accepted in same cycle as a write to the same line returns pre-write data; all earlier-accepted writes are visible to the read.
REQ-032 be_i all-zero write: accepted, occupies a slot, retires with no array change.
REQ-033 rd_req_i while busy: ignored, no state effect; requester holds it.

Reset
REQ-034 Reset SHALL force: state IDLE, counter 0, buffer empty, rvalid_o=0, rdata_o=0, rd_busy_o=0, write_ready_o=1, array all zero.
REQ-035 Reset mid-DRAIN or mid-READ SHALL abort the transaction: no rvalid_o, unretired writes discarded.

Verification
REQ-036 After reset, read addr 0x40 -> rvalid_o at T+2, rdata_o=0.
REQ-037 Write 0x10 data all-0xAA be all-ones, idle 2 cycles, read 0x10 -> rvalid_o at T+2, rdata_o all-0xAA.
REQ-038 Two writes to 0x20 (be=0x000F data 0x11.., then be=0xF000 data 0x22..), read 0x20 same cycle as second retire pending -> FSM DRAIN, rvalid_o at T+N+2, bytes 0-3=0x11, 12-15=0x22, rest 0.
REQ-039 Fill buffer (WBUF_DEPTH=2) during READ -> write_ready_o=0 on 3rd attempt, 3rd write not stored; after IDLE, drains 1/cycle.
REQ-040 Assert rst_n low during DRAIN -> no rvalid_o, buffered writes lost, re-read returns 0.
REQ-041 rd_req_i held during READ -> exactly one rvalid_o per accepted request, second accepted the cycle after rvalid_o.
